// File: rtl/intr_arbiter_pkg.sv
// Shared constants for the interrupt arbiter: source indices, the default
// control-register address and the sequencer state encoding.
package intr_pkg;

  localparam int SRC_TIMER = 0;
  localparam int SRC_KEYS  = 1;
  localparam int SRC_SWS   = 2;

  localparam logic [15:0] CADDR_DEFAULT = 16'hFFEC;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_INSERV = 2'd2
  } state_t;

endpackage

// File: rtl/intr_arbiter_if.sv
// Core/device-side signal bundle of the interrupt arbiter.
// The tri-state RBUS stays a plain module port.
interface intr_arbiter_if #(
  parameter int DBITS = 16,
  parameter int NSRC  = 3
);
  logic [NSRC-1:0]  INTR;
  logic             IE;
  logic             ACK;
  logic             RETI;
  logic             IRQ;
  logic [DBITS-1:0] SII;
  logic [DBITS-1:0] ABUS;
  logic [DBITS-1:0] WBUS;
  logic             RE;
  logic             WE;

  modport slave (
    input  INTR, IE, ACK, RETI, ABUS, WBUS, RE, WE,
    output IRQ, SII
  );

  modport master (
    output INTR, IE, ACK, RETI, ABUS, WBUS, RE, WE,
    input  IRQ, SII
  );
endinterface

// File: rtl/intr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set pend bit at or after ptr,
// wrapping modulo NSRC.
module rr_pick #(
  parameter int NSRC = 3,
  parameter int PW   = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic [NSRC-1:0] pend,
  input  logic [PW-1:0]   ptr,
  output logic            valid,
  output logic [PW-1:0]   gid
);

  logic [PW-1:0] idx;

  // Scan from the farthest candidate back toward ptr so the closest one wins.
  always_comb begin
    valid = 1'b0;
    gid   = '0;
    idx   = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      idx = PW'((int'(ptr) + i) % NSRC);
      if (pend[idx]) begin
        valid = 1'b1;
        gid   = idx;
      end
    end
  end

endmodule

// File: rtl/intr_arbiter.sv
// Interrupt arbiter/sequencer: masks device lines, grants round-robin,
// raises IRQ to the core and holds off further requests until RETI.
module intr_arbiter
  import intr_pkg::*;
#(
  parameter int               DBITS = 16,
  parameter int               NSRC  = 3,
  parameter logic [DBITS-1:0] CADDR = CADDR_DEFAULT
) (
  input  logic             CLK,
  input  logic             INIT,
  intr_arbiter_if.slave    bus,
  inout  wire  [DBITS-1:0] RBUS
);

  localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;

  state_t          state_q, state_d;
  logic [NSRC-1:0] mask_q, mask_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   gid_q, gid_d;
  logic            irq_q, irq_d;

  logic [NSRC-1:0]  pend;
  logic             pick_valid;
  logic [PW-1:0]    pick_gid;
  logic [DBITS-1:0] rd_data;
  logic             ctrl_hit_rd;
  logic             ctrl_hit_wr;
  logic             unused_wbus;

  assign pend        = bus.INTR & mask_q;
  assign ctrl_hit_rd = bus.RE && (bus.ABUS == CADDR);
  assign ctrl_hit_wr = bus.WE && (bus.ABUS == CADDR);
  assign unused_wbus = ^bus.WBUS[DBITS-1:NSRC];

  rr_pick #(.NSRC(NSRC), .PW(PW)) u_pick (
    .pend  (pend),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .gid   (pick_gid)
  );

  // ACK is checked before withdrawal: once the core commits entry it must win.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    irq_d   = irq_q;

    if (ctrl_hit_wr) begin
      mask_d = bus.WBUS[NSRC-1:0];
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.IE && pick_valid) begin
          gid_d   = pick_gid;
          irq_d   = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.ACK) begin
          irq_d   = 1'b0;
          state_d = ST_INSERV;
          ptr_d   = (gid_q == PW'(NSRC - 1)) ? '0 : gid_q + 1'b1;
        end else if (!bus.IE || !pend[gid_q]) begin
          irq_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_INSERV: begin
        irq_d = 1'b0;
        if (bus.RETI) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        irq_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (INIT) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      ptr_q   <= '0;
      gid_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      irq_q   <= irq_d;
    end
  end

  always_comb begin
    rd_data             = '0;
    rd_data[2*NSRC-1:0] = {pend, mask_q};
  end

  assign RBUS    = ctrl_hit_rd ? rd_data : {DBITS{1'bz}};
  assign bus.IRQ = irq_q;
  assign bus.SII = {{(DBITS - PW){1'b0}}, gid_q};

endmodule

// File: tb/tb_intr_arbiter.sv
// Self-checking bench for intr_arbiter: directed scenarios plus randomized
// traffic, all compared against a behavioural model of the arbiter rules.
module tb_intr_arbiter;
  import intr_pkg::*;

  localparam int          DBITS = 16;
  localparam int          NSRC  = 3;
  localparam logic [15:0] CADDR = 16'hFFEC;

  logic clk  = 1'b0;
  logic init = 1'b0;
  always #5 clk = ~clk;

  intr_arbiter_if #(.DBITS(DBITS), .NSRC(NSRC)) ifc ();
  wire [DBITS-1:0] rbus;

  intr_arbiter #(.DBITS(DBITS), .NSRC(NSRC), .CADDR(CADDR)) dut (
    .CLK  (clk),
    .INIT (init),
    .bus  (ifc),
    .RBUS (rbus)
  );

  int total = 0;
  int bad   = 0;

  // Model: requesting / in-service flags, mask, rotation pointer, grant id.
  logic [NSRC-1:0] m_mask;
  int              m_ptr;
  int              m_gid;
  bit              m_irq;
  bit              m_busy;

  function automatic int m_pick(input logic [NSRC-1:0] p, input int from);
    for (int k = 0; k < NSRC; k++) begin
      if (p[(from + k) % NSRC]) return (from + k) % NSRC;
    end
    return -1;
  endfunction

  // Advance one clock, update the model from the inputs the DUT sampled,
  // then clear the single-cycle pulses.
  task automatic tick();
    logic [NSRC-1:0] p;
    int g;
    @(posedge clk);
    p = ifc.INTR & m_mask;
    g = m_pick(p, m_ptr);
    if (init) begin
      m_mask = '0; m_ptr = 0; m_gid = 0; m_irq = 0; m_busy = 0;
    end else begin
      if (!m_irq && !m_busy) begin
        if (ifc.IE && g >= 0) begin
          m_gid = g;
          m_irq = 1;
        end
      end else if (m_irq) begin
        if (ifc.ACK) begin
          m_irq  = 0;
          m_busy = 1;
          m_ptr  = (m_gid + 1) % NSRC;
        end else if (!ifc.IE || !p[m_gid]) begin
          m_irq = 0;
        end
      end else if (ifc.RETI) begin
        m_busy = 0;
      end
      if (ifc.WE && ifc.ABUS == CADDR) m_mask = ifc.WBUS[NSRC-1:0];
    end
    #1;
    init     = 1'b0;
    ifc.ACK  = 1'b0;
    ifc.RETI = 1'b0;
    ifc.WE   = 1'b0;
  endtask

  task automatic write_mask(input logic [NSRC-1:0] m);
    ifc.ABUS = CADDR;
    ifc.WBUS = {13'h1ff8, m};
    ifc.WE   = 1'b1;
    tick();
    ifc.ABUS = '0;
  endtask

  task automatic test_reset();
    init = 1'b1;
    tick();
    total++;
    if (ifc.IRQ !== 1'b0) begin bad++; $display("[TB] FAIL reset_irq got=%0b want=0", ifc.IRQ); end
    total++;
    if (ifc.SII !== 16'h0000) begin bad++; $display("[TB] FAIL reset_sii got=%h want=0000", ifc.SII); end
    ifc.INTR = 3'b011;
    ifc.IE   = 1'b1;
    repeat (3) tick();
    total++;
    if (ifc.IRQ !== 1'b0) begin bad++; $display("[TB] FAIL masked_irq got=%0b want=0", ifc.IRQ); end
    ifc.RE   = 1'b1;
    ifc.ABUS = CADDR;
    #1;
    total++;
    if (rbus !== 16'h0000) begin bad++; $display("[TB] FAIL reset_read got=%h want=0000", rbus); end
    ifc.RE   = 1'b0;
    ifc.ABUS = '0;
  endtask

  task automatic test_basic_grant();
    ifc.INTR = 3'b110;
    ifc.IE   = 1'b1;
    write_mask(3'b111);
    tick();
    total++;
    if (ifc.IRQ !== 1'b1 || ifc.SII !== 16'd1) begin
      bad++; $display("[TB] FAIL first_grant irq=%0b sii=%0d want irq=1 sii=1", ifc.IRQ, ifc.SII);
    end
    ifc.ACK = 1'b1;
    tick();
    total++;
    if (ifc.IRQ !== 1'b0) begin bad++; $display("[TB] FAIL ack_drop got=%0b want=0", ifc.IRQ); end
    tick();
    total++;
    if (ifc.IRQ !== 1'b0 || ifc.SII !== 16'd1) begin
      bad++; $display("[TB] FAIL inserv_hold irq=%0b sii=%0d want irq=0 sii=1", ifc.IRQ, ifc.SII);
    end
    ifc.RETI = 1'b1;
    tick();
    total++;
    if (ifc.IRQ !== 1'b0) begin bad++; $display("[TB] FAIL reti_gap got=%0b want=0", ifc.IRQ); end
    tick();
    total++;
    if (ifc.IRQ !== 1'b1 || ifc.SII !== 16'd2) begin
      bad++; $display("[TB] FAIL rotate irq=%0b sii=%0d want irq=1 sii=2", ifc.IRQ, ifc.SII);
    end
  endtask

  task automatic test_round_robin();
    int exp_seq[4] = '{0, 1, 2, 0};
    ifc.INTR = 3'b111;
    ifc.ACK  = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      ifc.RETI = 1'b1;
      tick();
      tick();
      total++;
      if (ifc.IRQ !== 1'b1 || ifc.SII !== DBITS'(exp_seq[i])) begin
        bad++; $display("[TB] FAIL rr_seq[%0d] irq=%0b sii=%0d want irq=1 sii=%0d", i, ifc.IRQ, ifc.SII, exp_seq[i]);
      end
      ifc.ACK = 1'b1;
      tick();
    end
    ifc.RETI = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_withdraw();
    for (int n = 0; n < 4 && m_gid != SRC_SWS; n++) begin
      ifc.ACK = 1'b1;
      tick();
      ifc.RETI = 1'b1;
      tick();
      tick();
    end
    total++;
    if (ifc.IRQ !== 1'b1 || ifc.SII !== 16'd2) begin
      bad++; $display("[TB] FAIL pre_withdraw irq=%0b sii=%0d want irq=1 sii=2", ifc.IRQ, ifc.SII);
    end
    ifc.IE = 1'b0;
    tick();
    total++;
    if (ifc.IRQ !== 1'b0) begin bad++; $display("[TB] FAIL ie_withdraw got=%0b want=0", ifc.IRQ); end
    ifc.IE = 1'b1;
    tick();
    tick();
    total++;
    if (ifc.IRQ !== 1'b1 || ifc.SII !== DBITS'(m_gid)) begin
      bad++; $display("[TB] FAIL ie_return irq=%0b sii=%0d want irq=1 sii=%0d", ifc.IRQ, ifc.SII, m_gid);
    end
  endtask

  task automatic test_ack_vs_withdraw();
    ifc.ACK = 1'b1;
    ifc.IE  = 1'b0;
    tick();
    ifc.IE = 1'b1;
    repeat (3) tick();
    total++;
    if (ifc.IRQ !== 1'b0) begin bad++; $display("[TB] FAIL ack_wins got=%0b want=0", ifc.IRQ); end
    ifc.RETI = 1'b1;
    ifc.INTR = 3'b000;
    tick();
    ifc.RETI = 1'b1;
    ifc.ACK  = 1'b1;
    tick();
    ifc.INTR = 3'b111;
    tick();
    total++;
    if (ifc.IRQ !== 1'b1 || ifc.SII !== DBITS'(m_gid)) begin
      bad++; $display("[TB] FAIL idle_pulses irq=%0b sii=%0d want irq=1 sii=%0d", ifc.IRQ, ifc.SII, m_gid);
    end
  endtask

  task automatic test_init_inserv();
    ifc.ACK = 1'b1;
    tick();
    init = 1'b1;
    tick();
    ifc.RE   = 1'b1;
    ifc.ABUS = CADDR;
    #1;
    total++;
    if (ifc.IRQ !== 1'b0 || ifc.SII !== 16'd0 || rbus !== 16'h0000) begin
      bad++; $display("[TB] FAIL init_inserv irq=%0b sii=%0d rd=%h want 0 0 0000", ifc.IRQ, ifc.SII, rbus);
    end
    ifc.RE = 1'b0;
    write_mask(3'b111);
    tick();
    total++;
    if (ifc.IRQ !== 1'b1 || ifc.SII !== DBITS'(SRC_TIMER)) begin
      bad++; $display("[TB] FAIL ptr_restart irq=%0b sii=%0d want irq=1 sii=0", ifc.IRQ, ifc.SII);
    end
  endtask

  task automatic test_random();
    logic [15:0] exp_rd;
    for (int c = 0; c < 600; c++) begin
      ifc.INTR = NSRC'($urandom);
      ifc.IE   = ($urandom_range(3) != 0);
      ifc.ACK  = ($urandom_range(2) == 0);
      ifc.RETI = ($urandom_range(2) == 0);
      ifc.WE   = ($urandom_range(9) == 0);
      ifc.RE   = ($urandom_range(3) == 0);
      ifc.WBUS = 16'($urandom);
      ifc.ABUS = (ifc.WE || ifc.RE) ? CADDR : 16'h0100;
      init     = ($urandom_range(79) == 0);
      #1;
      if (ifc.RE) begin
        exp_rd      = '0;
        exp_rd[5:0] = {ifc.INTR & m_mask, m_mask};
        total++;
        if (rbus !== exp_rd) begin bad++; $display("[TB] FAIL rand_read c=%0d got=%h want=%h", c, rbus, exp_rd); end
      end
      tick();
      ifc.RE = 1'b0;
      total++;
      if (ifc.IRQ !== m_irq || ifc.SII !== DBITS'(m_gid)) begin
        bad++; $display("[TB] FAIL rand_out c=%0d irq=%0b sii=%0d want irq=%0b sii=%0d", c, ifc.IRQ, ifc.SII, m_irq, m_gid);
      end
    end
  endtask

  initial begin
    ifc.INTR = '0; ifc.IE = 1'b0; ifc.ACK = 1'b0; ifc.RETI = 1'b0;
    ifc.ABUS = '0; ifc.WBUS = '0; ifc.RE = 1'b0; ifc.WE = 1'b0;
    m_mask = '0; m_ptr = 0; m_gid = 0; m_irq = 0; m_busy = 0;
    test_reset();
    test_basic_grant();
    test_round_robin();
    test_withdraw();
    test_ack_vs_withdraw();
    test_init_inserv();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/intr_arbiter.md
# intr_arbiter

Interrupt arbiter and sequencer for the 16-bit pipelined core. It sits between the interrupt-capable memory-mapped devices (timer, keys, switches) and the core's control logic. It masks and arbitrates the device `INTR` lines round-robin, raises one interrupt request to the pipeline, and supplies the device ID for `SII`. It holds further requests off until the handler executes `RETI`. Software reaches its mask/pending register over the shared `ABUS`/`RBUS`/`WBUS` device bus.

## Interface
- `DBITS`, 16, data/address bus width
- `NSRC`, 3, number of interrupt sources; `INTR[0]`=timer, `[1]`=keys, `[2]`=switches
- `CADDR`, 16'hFFEC, address of the mask/pending control register

Ports:
- `CLK` in 1: core clock (PLL output).
- `INIT` in 1: reset, synchronous, active-high. This is already decided.
- `INTR` in NSRC: level interrupt lines from the devices.
- `IE` in 1: global interrupt enable, taken from SCS.
- `ACK` in 1: one-cycle pulse from the core in the cycle it commits interrupt entry (flush, SRA←PC, PC←SIH).
- `RETI` in 1: one-cycle pulse when `RETI` reaches the commit stage.
- `IRQ` out 1: interrupt request to the core.
- `SII` out DBITS: ID of the granted source, zero-extended.
- `ABUS` in DBITS, `WBUS` in DBITS, `RE` in 1, `WE` in 1: device bus.
- `RBUS` inout DBITS: driven only on a read of `CADDR`, else `z`.

## Operation
- `pend = INTR & MASK`. `MASK` is an NSRC-bit register; reset value is 0, so all sources are masked.
- Control register read returns `{zeros, pend[NSRC-1:0], MASK[NSRC-1:0]}`, with `MASK` in bits [NSRC-1:0] and `pend` in bits [2*NSRC-1:NSRC].
- A write to `CADDR` with `WE` loads `MASK <= WBUS[NSRC-1:0]`; upper bits are ignored.
- Round-robin pointer `PTR` (clog2(NSRC) bits, reset 0). The grant goes to the first set `pend` bit searching `PTR, PTR+1, …` with wrap modulo NSRC.
- On `ACK`, `PTR` becomes grant+1 with wrap: NSRC-1 → 0.
- FSM states:
  - IDLE: if `IE && |pend`, latch grant into `GID` and go to REQ.
  - REQ: `IRQ`=1.
    - On `ACK`, go to INSERV and advance `PTR`.
    - If `!IE` or `!pend[GID]` and no `ACK`, withdraw to IDLE. Arbitration restarts next cycle.
  - INSERV: `IRQ`=0 and no new grants. On `RETI`, go to IDLE.
- `SII = GID`, held constant from REQ entry through INSERV exit. `SII` keeps its last value in IDLE.
- `ACK` outside REQ is ignored. `RETI` outside INSERV is ignored.
- An `ACK` in the same cycle as a withdraw condition wins: the core has already committed, so go to INSERV.
- `INIT` forces IDLE, `MASK`=0, `PTR`=0, `GID`=0, `IRQ`=0 from any state, including mid-REQ and mid-INSERV.

## Timing
- Reset values: `IRQ`=0, `SII`=0, `RBUS`=z.
- `IRQ` is registered. It rises 1 cycle after the edge where IDLE sees `IE && |pend`, i.e. 1-cycle latency from a `pend` change.
- `IRQ` falls on the edge that samples `ACK`. The core must not see `IRQ`=1 in the cycle after its `ACK`.
- After `RETI` is sampled, the earliest next `IRQ` is 2 cycles later: IDLE for one cycle, then REQ.
- `RBUS` read is combinational and valid in the same cycle as `RE && ABUS==CADDR`, matching the other devices.
- A `MASK` write takes effect at the next edge. Masking the granted source while in REQ withdraws `IRQ` the cycle after.

## Structure
- Shared package (`intr_pkg`) holds the source index constants `SRC_TIMER=0`, `SRC_KEYS=1`, `SRC_SWS=2`, the `CADDR` default, and the FSM state encoding `ST_IDLE`, `ST_REQ`, `ST_INSERV`.
- Sub-module `rr_pick`: purely combinational round-robin priority picker. Inputs are `pend` and `PTR`; outputs are `valid` and `gid`. All state stays in `intr_arbiter`.

## Test plan
- Reset then timer and keys high, with `MASK` still 0 → `IRQ` stays 0. Read `CADDR` → 16'h0000 with `pend`=0.
- Write `MASK`=3'b111, `IE`=1, `INTR`=3'b110 → `IRQ`=1 one cycle later, `SII`=1. Pulse `ACK` → `IRQ`=0. `RETI` → after 2 cycles `IRQ`=1 with `SII`=2, showing round-robin rotation.
- All three sources held high with repeated `ACK`/`RETI` cycles → `SII` sequence 0, 1, 2, 0.
- In REQ with `SII`=2, drop `IE` → `IRQ`=0 next cycle and the state returns to IDLE. Raise `IE` again → `IRQ` returns.
- `ACK` and `IE` fall in the same cycle → state goes to INSERV and `IRQ` stays 0. A `RETI` pulse while in IDLE is ignored.
- `INIT` pulsed while in INSERV → `IRQ`=0, `SII`=0, `MASK` read back as 0, and `PTR` restarts at the timer source.
